// File: rtl/timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for timer_csr.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package timer_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_LOAD   = 3'd1;
    localparam logic [2:0] ADDR_PRESC  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_EVT    = 3'd4;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    localparam int STAT_DONE = 0;
    localparam int STAT_RUN  = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RUN       = 3'd2,
        ST_RELOAD    = 3'd3,
        ST_DONE_WAIT = 3'd4
    } state_t;

endpackage

// File: rtl/timer_csr_if.sv
// CPU word-access bus between the data-memory decoder and timer_csr.
// Latency: reads answer one cycle after the strobe; writes land the next cycle.
// Backpressure: none; every strobe is accepted.
interface timer_csr_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;

    modport master (output req_i, output we_i, output addr_i, output wdata_i,
                    input rdata_o, input rvalid_o);
    modport slave  (input req_i, input we_i, input addr_i, input wdata_i,
                    output rdata_o, output rvalid_o);
endinterface

// File: rtl/timer_csr.sv
// Control/status registers plus sequencing FSM driving an external count-down timer.
// Latency: write takes effect next cycle; read data one cycle after the strobe.
// Backpressure: none; the bus is always ready and done_i is sampled every cycle.
module timer_csr
    import timer_pkg::*;
#(
    parameter int TIMER_BITS  = 30,
    parameter int SCALER_BITS = 4,
    parameter int EVT_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    timer_csr_if.slave             bus,
    output logic [TIMER_BITS-1:0]  start_o,
    output logic [SCALER_BITS-1:0] prescaler_o,
    output logic                   enable_o,
    input  logic                   done_i,
    output logic                   irq_o
);

    state_t                 state, state_nxt;
    logic                   copy_shadow;
    logic [2:0]             ctrl, ctrl_nxt;
    logic [TIMER_BITS-1:0]  load;
    logic [SCALER_BITS-1:0] presc;
    logic                   done_flag, done_flag_nxt;
    logic [EVT_BITS-1:0]    evt, evt_nxt;
    logic                   done_q;
    logic                   done_rise;
    logic                   wr, rd;
    logic [31:0]            rd_val;
    logic                   unused_wdata;

    assign wr           = bus.req_i & bus.we_i;
    assign rd           = bus.req_i & ~bus.we_i;
    assign unused_wdata = ^bus.wdata_i;

    // Timer completions only count while actively counting.
    assign done_rise = done_i & ~done_q & (state == ST_RUN);

    // Next-state logic; shadows are released to the timer on entry to ARM and on leaving RELOAD.
    always_comb begin
        state_nxt   = state;
        copy_shadow = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl[CTRL_EN]) begin
                    state_nxt   = ST_ARM;
                    copy_shadow = 1'b1;
                end
            end
            ST_ARM:  state_nxt = ctrl[CTRL_EN] ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (!ctrl[CTRL_EN])
                    state_nxt = ST_IDLE;
                else if (done_rise)
                    state_nxt = ctrl[CTRL_AR] ? ST_RELOAD : ST_DONE_WAIT;
            end
            ST_RELOAD: begin
                if (!ctrl[CTRL_EN]) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt   = ST_RUN;
                    copy_shadow = 1'b1;
                end
            end
            ST_DONE_WAIT: begin
                if (!ctrl[CTRL_EN])
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register next values: a completion beats a W1C, an EVT write beats an increment.
    always_comb begin
        ctrl_nxt = ctrl;
        if (wr && bus.addr_i == ADDR_CTRL)
            ctrl_nxt = bus.wdata_i[2:0];

        done_flag_nxt = done_flag;
        if (wr && bus.addr_i == ADDR_STATUS && bus.wdata_i[STAT_DONE])
            done_flag_nxt = 1'b0;
        if (done_rise)
            done_flag_nxt = 1'b1;

        evt_nxt = evt;
        if (wr && bus.addr_i == ADDR_EVT)
            evt_nxt = '0;
        else if (done_rise && evt != '1)
            evt_nxt = evt + 1'b1;
    end

    // Read mux; unmapped bits and addresses return zero.
    always_comb begin
        rd_val = '0;
        case (bus.addr_i)
            ADDR_CTRL:   rd_val[2:0] = ctrl;
            ADDR_LOAD:   rd_val[TIMER_BITS-1:0] = load;
            ADDR_PRESC:  rd_val[SCALER_BITS-1:0] = presc;
            ADDR_STATUS: begin
                rd_val[STAT_DONE] = done_flag;
                rd_val[STAT_RUN]  = (state != ST_IDLE);
            end
            ADDR_EVT:    rd_val[EVT_BITS-1:0] = evt;
            default:     rd_val = '0;
        endcase
    end

    // State, registers and registered timer/bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ctrl        <= '0;
            load        <= '0;
            presc       <= '0;
            done_flag   <= 1'b0;
            evt         <= '0;
            done_q      <= 1'b0;
            start_o     <= '0;
            prescaler_o <= '0;
            enable_o    <= 1'b0;
            irq_o       <= 1'b0;
            bus.rdata_o  <= '0;
            bus.rvalid_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctrl      <= ctrl_nxt;
            done_flag <= done_flag_nxt;
            evt       <= evt_nxt;
            done_q    <= done_i;
            if (wr && bus.addr_i == ADDR_LOAD)
                load <= bus.wdata_i[TIMER_BITS-1:0];
            if (wr && bus.addr_i == ADDR_PRESC)
                presc <= bus.wdata_i[SCALER_BITS-1:0];
            if (copy_shadow) begin
                start_o     <= load;
                prescaler_o <= presc;
            end
            enable_o     <= (state_nxt == ST_RUN) || (state_nxt == ST_DONE_WAIT);
            irq_o        <= done_flag_nxt & ctrl_nxt[CTRL_IE];
            bus.rvalid_o <= rd;
            bus.rdata_o  <= rd ? rd_val : 32'd0;
        end
    end

endmodule
